ex_mem_reg: RTL and testbench

- Registered pipeline boundary between the EX stage and the MEM stage.
- Captures the EX result, register-write enable and destination register address, then presents them to MEM one cycle later.
- Uses a valid/ready handshake on both sides with a two-entry skid buffer, so a MEM-side stall never drops data and `in_ready` is a pure register output (no combinational ready path back into EX).
- Synchronous flush for exception/branch recovery.

---
 rtl/ex_mem_reg.sv | 147 ++++++++++++++
 tb/tb_ex_mem_reg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_reg
// Description : EX -> MEM pipeline register. A head entry plus one skid entry
//               behind valid/ready handshakes on both sides. in_ready comes
//               straight from a flop, so there is no combinational path from
//               MEM back into EX. Synchronous flush, asynchronous active-low
//               reset. Bubbles present all-zero data toward MEM.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     result_in,
    input  logic                      write_reg_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] write_reg_addr_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     result_out,
    output logic                      write_reg_en_out,
    output logic [REG_ADDR_WIDTH-1:0] write_reg_addr_out
);

    // Head entry (visible to MEM)
    logic                      r_head_valid;
    logic [DATA_WIDTH-1:0]     r_head_result;
    logic                      r_head_en;
    logic [REG_ADDR_WIDTH-1:0] r_head_addr;

    // Skid entry (holds the second entry while MEM stalls)
    logic                      r_skid_valid;
    logic [DATA_WIDTH-1:0]     r_skid_result;
    logic                      r_skid_en;
    logic [REG_ADDR_WIDTH-1:0] r_skid_addr;

    // Registered ready toward EX
    logic                      r_in_ready;

    // Next-state values
    logic                      w_head_valid_nxt;
    logic [DATA_WIDTH-1:0]     w_head_result_nxt;
    logic                      w_head_en_nxt;
    logic [REG_ADDR_WIDTH-1:0] w_head_addr_nxt;
    logic                      w_skid_valid_nxt;
    logic [DATA_WIDTH-1:0]     w_skid_result_nxt;
    logic                      w_skid_en_nxt;
    logic [REG_ADDR_WIDTH-1:0] w_skid_addr_nxt;
    logic                      w_in_ready_nxt;

    // Handshake events for this cycle. r_in_ready is 0 throughout reset, so
    // nothing is accepted until the first edge after release.
    logic                      w_acc;
    logic                      w_pop;

    assign w_acc = in_valid && r_in_ready;
    assign w_pop = r_head_valid && out_ready;

    // Next-state selection: flush dominates, then pop/accept combinations
    always_comb begin
        w_head_valid_nxt  = r_head_valid;
        w_head_result_nxt = r_head_result;
        w_head_en_nxt     = r_head_en;
        w_head_addr_nxt   = r_head_addr;
        w_skid_valid_nxt  = r_skid_valid;
        w_skid_result_nxt = r_skid_result;
        w_skid_en_nxt     = r_skid_en;
        w_skid_addr_nxt   = r_skid_addr;

        if (flush) begin
            // Discard everything, including any entry accepted this cycle.
            // Stale data fields stay behind but are masked at the outputs.
            w_head_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_pop) begin
            if (r_skid_valid) begin
                // Full: skid advances into head; accept impossible here
                w_head_result_nxt = r_skid_result;
                w_head_en_nxt     = r_skid_en;
                w_head_addr_nxt   = r_skid_addr;
                w_skid_valid_nxt  = 1'b0;
            end else if (w_acc) begin
                // One entry, pop and accept together: new entry replaces head
                w_head_result_nxt = result_in;
                w_head_en_nxt     = write_reg_en_in;
                w_head_addr_nxt   = write_reg_addr_in;
            end else begin
                w_head_valid_nxt  = 1'b0;
            end
        end else if (w_acc) begin
            if (r_head_valid) begin
                // Head is stalled: park the new entry in the skid slot
                w_skid_valid_nxt  = 1'b1;
                w_skid_result_nxt = result_in;
                w_skid_en_nxt     = write_reg_en_in;
                w_skid_addr_nxt   = write_reg_addr_in;
            end else begin
                w_head_valid_nxt  = 1'b1;
                w_head_result_nxt = result_in;
                w_head_en_nxt     = write_reg_en_in;
                w_head_addr_nxt   = write_reg_addr_in;
            end
        end

        // Ready only depends on whether the skid slot will be free
        w_in_ready_nxt = !w_skid_valid_nxt;
    end

    // State registers with asynchronous clear of valids, data and ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head_valid  <= 1'b0;
            r_head_result <= '0;
            r_head_en     <= 1'b0;
            r_head_addr   <= '0;
            r_skid_valid  <= 1'b0;
            r_skid_result <= '0;
            r_skid_en     <= 1'b0;
            r_skid_addr   <= '0;
            r_in_ready    <= 1'b0;
        end else begin
            r_head_valid  <= w_head_valid_nxt;
            r_head_result <= w_head_result_nxt;
            r_head_en     <= w_head_en_nxt;
            r_head_addr   <= w_head_addr_nxt;
            r_skid_valid  <= w_skid_valid_nxt;
            r_skid_result <= w_skid_result_nxt;
            r_skid_en     <= w_skid_en_nxt;
            r_skid_addr   <= w_skid_addr_nxt;
            r_in_ready    <= w_in_ready_nxt;
        end
    end

    // Outputs: bubbles always carry zero data toward MEM
    assign in_ready           = r_in_ready;
    assign out_valid          = r_head_valid;
    assign result_out         = r_head_valid ? r_head_result : '0;
    assign write_reg_en_out   = r_head_valid & r_head_en;
    assign write_reg_addr_out = r_head_valid ? r_head_addr : '0;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_reg
// Description : Self-checking bench for ex_mem_reg. A queue-based FIFO model
//               (depth 2) predicts outputs; directed scenarios are followed
//               by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_reg;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic [DW-1:0] res;
        logic          en;
        logic [AW-1:0] addr;
    } entry_t;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] result_in;
    logic          write_reg_en_in;
    logic [AW-1:0] write_reg_addr_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result_out;
    logic          write_reg_en_out;
    logic [AW-1:0] write_reg_addr_out;

    entry_t        q[$];
    logic          m_ready;
    int            n_checks;
    int            n_fail;

    ex_mem_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .result_in          (result_in),
        .write_reg_en_in    (write_reg_en_in),
        .write_reg_addr_in  (write_reg_addr_in),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .result_out         (result_out),
        .write_reg_en_out   (write_reg_en_out),
        .write_reg_addr_out (write_reg_addr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Compare every output against the FIFO model
    task automatic check_outputs(input string tag);
        entry_t h;
        logic   v;
        v = (q.size() > 0);
        h = v ? q[0] : '0;
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".result"},    64'(result_out), 64'(h.res));
        chk({tag, ".en"},        64'(write_reg_en_out), 64'(h.en));
        chk({tag, ".addr"},      64'(write_reg_addr_out), 64'(h.addr));
        chk({tag, ".in_ready"},  64'(in_ready), 64'(m_ready));
    endtask

    // Model of one rising edge, using the inputs that were applied to it
    task automatic model_edge;
        logic acc;
        logic pop;
        entry_t e;
        if (!rst) begin
            q.delete();
            m_ready = 1'b0;
            return;
        end
        acc = in_valid && m_ready;
        pop = (q.size() > 0) && out_ready;
        e.res  = result_in;
        e.en   = write_reg_en_in;
        e.addr = write_reg_addr_in;
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        m_ready = (q.size() < 2);
    endtask

    // Called at a negedge: apply inputs, take one edge, check at next negedge
    task automatic cyc(input string tag, input logic v, input logic [DW-1:0] d,
                       input logic en, input logic [AW-1:0] a,
                       input logic ordy, input logic fl);
        in_valid          = v;
        result_in         = d;
        write_reg_en_in   = en;
        write_reg_addr_in = a;
        out_ready         = ordy;
        flush             = fl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_ready  = 1'b0;
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        result_in = '0;
        write_reg_en_in = 1'b0;
        write_reg_addr_in = '0;

        #2;
        check_outputs("reset");
        @(negedge clk);
        cyc("reset_hold", 1'b1, 32'h1234, 1'b1, 5'd1, 1'b1, 1'b0);
        rst = 1'b1;
        cyc("release", 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        chk("ready_after_release", 64'(in_ready), 64'd1);

        // Reset then stream
        cyc("stream0", 1'b1, 32'h11, 1'b1, 5'd1, 1'b1, 1'b0);
        cyc("stream1", 1'b1, 32'h22, 1'b1, 5'd2, 1'b1, 1'b0);
        cyc("stream2", 1'b1, 32'h33, 1'b1, 5'd3, 1'b1, 1'b0);
        cyc("stream3", 1'b0, 32'h0,  1'b0, 5'd0, 1'b1, 1'b0);
        cyc("stream4", 1'b0, 32'h0,  1'b0, 5'd0, 1'b1, 1'b0);

        // Backpressure fill then drain
        cyc("bp0", 1'b1, 32'hA, 1'b1, 5'd3, 1'b0, 1'b0);
        cyc("bp1", 1'b1, 32'hB, 1'b1, 5'd4, 1'b0, 1'b0);
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        chk("bp_head", 64'(result_out), 64'hA);
        cyc("bp2", 1'b1, 32'hC, 1'b1, 5'd5, 1'b0, 1'b0);
        cyc("bp3", 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        chk("bp_second", 64'(result_out), 64'hB);
        cyc("bp4", 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);

        // Simultaneous accept and pop at occupancy 1
        cyc("ap0", 1'b1, 32'h5, 1'b0, 5'd7, 1'b0, 1'b0);
        cyc("ap1", 1'b1, 32'h6, 1'b1, 5'd8, 1'b1, 1'b0);
        chk("ap_head", 64'(result_out), 64'h6);
        cyc("ap2", 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);

        // Flush at occupancy 2 with a concurrent input
        cyc("fl0", 1'b1, 32'h7, 1'b1, 5'd1, 1'b0, 1'b0);
        cyc("fl1", 1'b1, 32'h8, 1'b1, 5'd2, 1'b0, 1'b0);
        cyc("fl2", 1'b1, 32'h9, 1'b1, 5'd3, 1'b0, 1'b1);
        chk("fl_valid", 64'(out_valid), 64'd0);
        cyc("fl3", 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);

        // Bubble zeroing
        cyc("bub0", 1'b1, 32'hDEADBEEF, 1'b1, 5'd31, 1'b0, 1'b0);
        cyc("bub1", 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        cyc("bub2", 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("bub_result", 64'(result_out), 64'd0);

        // Asynchronous reset in the middle of a stall
        cyc("ar0", 1'b1, 32'h41, 1'b1, 5'd9, 1'b0, 1'b0);
        cyc("ar1", 1'b1, 32'h42, 1'b1, 5'd10, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        q.delete();
        m_ready = 1'b0;
        #1;
        check_outputs("ar_async");
        @(negedge clk);
        cyc("ar_hold", 1'b1, 32'h43, 1'b1, 5'd11, 1'b1, 1'b0);
        rst = 1'b1;
        cyc("ar_rel", 1'b1, 32'h44, 1'b1, 5'd12, 1'b0, 1'b0);
        cyc("ar_push", 1'b1, 32'h77, 1'b1, 5'd13, 1'b0, 1'b0);
        chk("ar_first", 64'(result_out), 64'h77);
        cyc("ar_drain", 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rnd",
                ($urandom_range(0, 9) < 7),
                $urandom(),
                1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)),
                ($urandom_range(0, 9) < 6),
                ($urandom_range(0, 39) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
